// File: rtl/ball_fx.sv
// ball_fx: fixed-point ball physics, one update per frame_clk edge.
// Serve, play and goal-freeze sequencing with bounces and goal detection.
module ball_fx #(
  parameter int POS_W           = 10,
  parameter int FRAC            = 4,
  parameter int VEL_W           = 12,
  parameter int RADIUS          = 15,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int FLOOR           = 320,
  parameter int CEIL            = 0,
  parameter int INIT_X          = 320,
  parameter int INIT_Y          = 50,
  parameter int GOAL_Y_TOP      = 176,
  parameter int GOAL_Y_BOTTOM   = 316,
  parameter int LEFT_GOAL_X     = 32,
  parameter int RIGHT_GOAL_X    = 604,
  parameter int CROSSBAR_Y      = 156,
  parameter int LEFT_BAR_X_MAX  = 48,
  parameter int RIGHT_BAR_X_MIN = 588,
  parameter int GRAVITY         = 16,
  parameter int VMAX            = 240,
  parameter int FRICTION        = 16,
  parameter int SETTLE          = 32,
  parameter int REST_NUM        = 3,
  parameter int REST_SHIFT      = 2,
  parameter int FRIC_PERIOD     = 32,
  parameter int SERVE_FRAMES    = 60,
  parameter int FREEZE_FRAMES   = 90
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    pause,
  input  logic                    apply_force,
  input  logic signed [VEL_W-1:0] force_x,
  input  logic signed [VEL_W-1:0] force_y,
  output logic        [POS_W-1:0] BallX,
  output logic        [POS_W-1:0] BallY,
  output logic        [POS_W-1:0] BallS,
  output logic signed [VEL_W-1:0] BallVelX,
  output logic signed [VEL_W-1:0] BallVelY,
  output logic                    goal_left,
  output logic                    goal_right,
  output logic        [1:0]       state,
  output logic                    on_floor
);

  localparam int PW = POS_W + FRAC;
  localparam int AW = PW + 4;
  localparam int CMAX = (SERVE_FRAMES > FREEZE_FRAMES) ?
                        SERVE_FRAMES : FREEZE_FRAMES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(FRIC_PERIOD + 1);

  typedef logic signed [AW-1:0] w_t;
  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_GOAL  = 2'd2
  } st_t;

  localparam w_t ZERO   = '0;
  localparam w_t VMAX_W = w_t'(VMAX);
  localparam w_t SETL_W = w_t'(SETTLE);
  localparam w_t FRIC_W = w_t'(FRICTION);
  localparam w_t GRAV_W = w_t'(GRAVITY);
  localparam w_t REST_W = w_t'(REST_NUM);
  localparam w_t PMAX_W = w_t'((1 << PW) - 1);

  localparam w_t FLOOR_P = w_t'(FLOOR - RADIUS);
  localparam w_t CEIL_P  = w_t'(CEIL + RADIUS);
  localparam w_t BAR_P   = w_t'(CROSSBAR_Y - RADIUS);
  localparam w_t WL_P    = w_t'(X_MIN + RADIUS);
  localparam w_t WR_P    = w_t'(X_MAX - RADIUS);
  localparam w_t GT_P    = w_t'(GOAL_Y_TOP);
  localparam w_t GB_P    = w_t'(GOAL_Y_BOTTOM);
  localparam w_t GL_P    = w_t'(LEFT_GOAL_X);
  localparam w_t GR_P    = w_t'(RIGHT_GOAL_X);
  localparam w_t BLL_P   = w_t'(X_MIN);
  localparam w_t BLH_P   = w_t'(LEFT_BAR_X_MAX);
  localparam w_t BRL_P   = w_t'(RIGHT_BAR_X_MIN);
  localparam w_t BRH_P   = w_t'(X_MAX);

  localparam logic [PW-1:0] INIT_XF  = PW'(INIT_X << FRAC);
  localparam logic [PW-1:0] INIT_YF  = PW'(INIT_Y << FRAC);
  localparam logic [PW-1:0] FLOOR_YF = PW'((FLOOR - RADIUS) << FRAC);
  localparam logic [PW-1:0] CEIL_YF  = PW'((CEIL + RADIUS) << FRAC);
  localparam logic [PW-1:0] BAR_YF   = PW'((CROSSBAR_Y - RADIUS) << FRAC);
  localparam logic [PW-1:0] WALL_LF  = PW'((X_MIN + RADIUS) << FRAC);
  localparam logic [PW-1:0] WALL_RF  = PW'((X_MAX - RADIUS) << FRAC);

  function automatic w_t sat_v(input w_t v);
    if (v > VMAX_W) return VMAX_W;
    if (v < -VMAX_W) return -VMAX_W;
    return v;
  endfunction

  function automatic w_t refl(input w_t v);
    return (-(v * REST_W)) >>> REST_SHIFT;
  endfunction

  function automatic w_t settle(input w_t v);
    if (v < SETL_W && v > -SETL_W) return ZERO;
    return v;
  endfunction

  function automatic w_t toward0(input w_t v);
    if (v > FRIC_W) return v - FRIC_W;
    if (v < -FRIC_W) return v + FRIC_W;
    return ZERO;
  endfunction

  function automatic logic [PW-1:0] to_pos(input w_t p);
    if (p[AW-1]) return '0;
    if (p > PMAX_W) return '1;
    return p[PW-1:0];
  endfunction

  logic [PW-1:0]       x_q, x_d, y_q, y_d;
  logic [VEL_W-1:0]    vx_q, vx_d, vy_q, vy_d;
  st_t                 state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FW-1:0]       fric_q, fric_d;
  logic                gl_q, gl_d, gr_q, gr_d;
  logic                of_q, of_d;

  w_t   vx_n, vy_n, x_n, y_n, xp, yp, yo;
  w_t   vx_w, vy_b;
  logic in_gy, hit_gl, hit_gr, in_bar_x;
  logic hit_floor, hit_ceil, hit_bar, hit_wl, hit_wr;

  always_comb begin
    vx_n = sat_v(w_t'(signed'(vx_q))
           + (apply_force ? w_t'(force_x) : ZERO));
    vy_n = sat_v(w_t'(signed'(vy_q)) + GRAV_W
           + (apply_force ? w_t'(force_y) : ZERO));
    x_n  = w_t'(x_q) + vx_n;
    y_n  = w_t'(y_q) + vy_n;
    xp   = x_n >>> FRAC;
    yp   = y_n >>> FRAC;
    yo   = w_t'(y_q) >>> FRAC;
    vy_b = settle(refl(vy_n));

    in_gy  = (yp >= GT_P) && (yp <= GB_P);
    hit_gl = in_gy && (xp <= GL_P);
    hit_gr = in_gy && !hit_gl && (xp >= GR_P);

    in_bar_x = ((xp >= BLL_P) && (xp <= BLH_P)) ||
               ((xp >= BRL_P) && (xp <= BRH_P));
    hit_floor = (yp >= FLOOR_P);
    hit_ceil  = !hit_floor && (yp <= CEIL_P);
    // Only a ball falling through the bar line this frame lands on it.
    hit_bar   = !hit_floor && !hit_ceil && in_bar_x &&
                !vy_n[AW-1] && (vy_n != ZERO) &&
                (yo < BAR_P) && (yp >= BAR_P);
    hit_wl    = !in_gy && (xp <= WL_P);
    hit_wr    = !in_gy && !hit_wl && (xp >= WR_P);

    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    fric_d  = fric_q;
    of_d    = of_q;
    gl_d    = 1'b0;
    gr_d    = 1'b0;
    vx_w    = vx_n;

    if (!pause) begin
      unique case (state_q)
        S_SERVE: begin
          x_d    = INIT_XF;
          y_d    = INIT_YF;
          vx_d   = '0;
          vy_d   = '0;
          of_d   = 1'b0;
          fric_d = '0;
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PLAY: begin
          if (hit_gl || hit_gr) begin
            x_d     = to_pos(x_n);
            y_d     = to_pos(y_n);
            vx_d    = '0;
            vy_d    = '0;
            of_d    = 1'b0;
            fric_d  = '0;
            cnt_d   = '0;
            gl_d    = hit_gl;
            gr_d    = hit_gr;
            state_d = S_GOAL;
          end else begin
            y_d  = to_pos(y_n);
            vy_d = vy_n[VEL_W-1:0];
            if (hit_floor) begin
              y_d  = FLOOR_YF;
              vy_d = vy_b[VEL_W-1:0];
            end else if (hit_ceil) begin
              y_d  = CEIL_YF;
              vy_d = vy_b[VEL_W-1:0];
            end else if (hit_bar) begin
              y_d  = BAR_YF;
              vy_d = vy_b[VEL_W-1:0];
            end
            x_d = to_pos(x_n);
            if (hit_wl) begin
              x_d  = WALL_LF;
              vx_w = refl(vx_n);
            end else if (hit_wr) begin
              x_d  = WALL_RF;
              vx_w = refl(vx_n);
            end
            fric_d = '0;
            if (hit_floor) begin
              if (fric_q == FW'(FRIC_PERIOD - 1)) begin
                vx_w = toward0(vx_w);
              end else begin
                fric_d = fric_q + FW'(1);
              end
            end
            vx_d = vx_w[VEL_W-1:0];
            of_d = hit_floor;
          end
        end
        S_GOAL: begin
          vx_d   = '0;
          vy_d   = '0;
          of_d   = 1'b0;
          fric_d = '0;
          if (cnt_q == CW'(FREEZE_FRAMES - 1)) begin
            state_d = S_SERVE;
            cnt_d   = '0;
            x_d     = INIT_XF;
            y_d     = INIT_YF;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_SERVE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q     <= INIT_XF;
      y_q     <= INIT_YF;
      vx_q    <= '0;
      vy_q    <= '0;
      state_q <= S_SERVE;
      cnt_q   <= '0;
      fric_q  <= '0;
      gl_q    <= 1'b0;
      gr_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fric_q  <= fric_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
      of_q    <= of_d;
    end
  end

  assign BallX      = x_q[PW-1:FRAC];
  assign BallY      = y_q[PW-1:FRAC];
  assign BallS      = POS_W'(RADIUS);
  assign BallVelX   = vx_q;
  assign BallVelY   = vy_q;
  assign goal_left  = gl_q;
  assign goal_right = gr_q;
  assign state      = state_q;
  assign on_floor   = of_q;

endmodule
